led_bank_arbiter: RTL and testbench



---
 rtl/led_bank_arbiter.sv | 146 ++++++++++++++
 tb/tb_led_bank_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter that shares one LED bank between NUM_REQ pattern sources.
// A winner keeps the bank for HOLD_TICKS prescaler ticks before it can be preempted.
module led_bank_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LED_WIDTH   = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int TICK_COUNT  = 25_000_000,
  parameter int HOLD_TICKS  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LED_WIDTH-1:0]   pattern,
  output logic [NUM_REQ-1:0]             grant,
  output logic [LED_WIDTH-1:0]           led,
  output logic                           tick,
  output logic                           busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_CAP = HW'(HOLD_TICKS);
  localparam logic [COUNT_WIDTH-1:0] TICK_TERM = COUNT_WIDTH'(TICK_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   tick_q, tick_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;
  logic                   busy_q, busy_d;
  logic [OW-1:0]          last_q, last_d;
  logic [HW-1:0]          hold_q, hold_d;

  logic                   pick_valid;
  logic [OW-1:0]          pick_idx;
  logic [OW-1:0]          cand;
  logic                   owner_req;
  logic                   others_req;
  logic [LED_WIDTH-1:0]   owner_pat;

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OW'((int'(last_q) + k) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_req  = req[last_q];
  assign others_req = |(req & ~grant_q);
  assign owner_pat  = pattern[last_q*LED_WIDTH +: LED_WIDTH];

  always_comb begin
    cnt_d   = (cnt_q == TICK_TERM) ? '0 : cnt_q + COUNT_WIDTH'(1);
    tick_d  = (cnt_q == TICK_TERM);
    state_d = state_q;
    grant_d = grant_q;
    led_d   = led_q;
    last_d  = last_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        led_d   = '0;
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          last_d            = pick_idx;
          hold_d            = '0;
          state_d           = OWN;
        end
      end
      OWN: begin
        led_d = owner_pat;
        if (tick_q && hold_q != HOLD_CAP) begin
          hold_d = hold_q + HW'(1);
        end
        // A release takes precedence; it lands in SWITCH just like preemption.
        if (!owner_req || (hold_q == HOLD_CAP && others_req)) begin
          grant_d = '0;
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d[pick_idx] = 1'b1;
          last_d            = pick_idx;
          hold_d            = '0;
          state_d           = OWN;
        end else begin
          led_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        led_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      grant_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= OW'(NUM_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign tick  = tick_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter: expected {grant, led, busy} go into a queue
// as each step is driven and are popped when the DUT output is sampled on the falling edge.
module tb_led_bank_arbiter;

  localparam int NR = 4;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*LW-1:0]  pattern = '0;
  logic [NR-1:0]     grant;
  logic [LW-1:0]     led;
  logic              tick;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         own_q[$];

  // Preemption timeline, cycle numbers counted in rising edges after reset release.
  int         s3_cyc[10] = '{1, 2, 9, 10, 11, 12, 17, 18, 19, 20};
  logic [3:0] s3_g[10]   = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                             4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001};
  logic [3:0] s3_l[10]   = '{4'h0, 4'h9, 4'h9, 4'h9, 4'h9,
                             4'h6, 4'h6, 4'h6, 4'h6, 4'h9};

  led_bank_arbiter #(
    .NUM_REQ    (NR),
    .LED_WIDTH  (LW),
    .COUNT_WIDTH(8),
    .TICK_COUNT (3),
    .HOLD_TICKS (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .pattern(pattern),
    .grant  (grant),
    .led    (led),
    .tick   (tick),
    .busy   (busy)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  // Driver and scoreboard tasks.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] l);
    exp_q.push_back({g, l, |g});
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [8:0] exp;
    string      tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed grant=%b led=%h, expected a queued entry", grant, led);
      return;
    end
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    assert ({grant, led, busy} === exp) else begin
      errors++;
      $error("FAIL %s: observed grant=%b led=%h busy=%b, expected grant=%b led=%h busy=%b",
             tag, grant, led, busy, exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    step(2);
    expect_out("reset_outputs", 4'b0000, 4'h0);
    check_out();
    check_bit("reset_tick", tick, 1'b0);
    rst_n = 1'b1;
  endtask

  // Stimulus: one linear sequence of directed steps.
  initial begin
    int at;
    int seen;
    int tenure_ticks;
    logic [3:0] prev_g;

    // Reset then idle: tick every 4th cycle, outputs stay zero.
    apply_reset(4'b0000);
    for (int n = 1; n <= 20; n++) begin
      expect_out("idle_outputs", 4'b0000, 4'h0);
      step(1);
      check_out();
      check_bit("idle_tick", tick, (n % 4) == 0);
    end

    // Single requester: grant after one edge, led one edge later, held for 50+ cycles.
    pattern = 16'h000A;
    apply_reset(4'b0001);
    expect_out("single_grant", 4'b0001, 4'h0);
    expect_out("single_led", 4'b0001, 4'hA);
    step(1);
    check_out();
    step(1);
    check_out();
    for (int n = 0; n < 48; n++) begin
      expect_out("single_hold", 4'b0001, 4'hA);
      step(1);
      check_out();
    end
    pattern = 16'h0005;
    expect_out("single_follow", 4'b0001, 4'h5);
    step(1);
    check_out();

    // Preemption 0 -> 1 -> 0 after two ticks of dwell each.
    pattern = 16'hDC69;
    apply_reset(4'b0011);
    for (int i = 0; i < 10; i++) expect_out($sformatf("preempt_c%0d", s3_cyc[i]), s3_g[i], s3_l[i]);
    at = 0;
    for (int i = 0; i < 10; i++) begin
      step(s3_cyc[i] - at);
      at = s3_cyc[i];
      check_out();
    end

    // Voluntary release by req2 after one tick, then release of everything.
    apply_reset(4'b1100);
    expect_out("release_grant", 4'b0100, 4'h0);
    expect_out("release_led", 4'b0100, 4'hC);
    expect_out("release_pre", 4'b0100, 4'hC);
    step(1);
    check_out();
    step(1);
    check_out();
    step(4);
    check_out();
    req = 4'b1000;
    expect_out("release_switch", 4'b0000, 4'hC);
    expect_out("release_next", 4'b1000, 4'hC);
    expect_out("release_next_led", 4'b1000, 4'hD);
    step(1);
    check_out();
    step(1);
    check_out();
    step(1);
    check_out();
    req = 4'b0000;
    expect_out("drop_switch", 4'b0000, 4'hD);
    expect_out("drop_idle", 4'b0000, 4'h0);
    expect_out("drop_idle_hold", 4'b0000, 4'h0);
    step(1);
    check_out();
    step(1);
    check_out();
    step(1);
    check_out();

    // Round-robin fairness with all four requesting for 40 ticks.
    apply_reset(4'b1111);
    for (int i = 0; i < 32; i++) own_q.push_back(i % 4);
    prev_g = 4'b0000;
    seen = 0;
    tenure_ticks = 0;
    for (int n = 1; n <= 160; n++) begin
      step(1);
      check_bit("rr_onehot", $countones(grant) <= 1, 1'b1);
      check_bit("rr_gap", (prev_g != 0) && (grant != 0) && (grant != prev_g), 1'b0);
      if (prev_g == 4'b0000 && grant != 4'b0000) begin
        if (seen > 0) check_bit("rr_tenure_ticks", (tenure_ticks >= 2) && (tenure_ticks <= 3), 1'b1);
        checks++;
        if (own_q.size() == 0) begin
          errors++;
          $error("FAIL rr_order: observed grant=%b, expected no further owner", grant);
        end else begin
          int exp_owner;
          exp_owner = own_q.pop_front();
          assert (grant === 4'(1 << exp_owner)) else begin
            errors++;
            $error("FAIL rr_order: observed grant=%b, expected grant=%b", grant, 4'(1 << exp_owner));
          end
        end
        tenure_ticks = 0;
        seen++;
      end
      if (grant != 4'b0000 && tick) tenure_ticks++;
      prev_g = grant;
    end
    check_bit("rr_progress", seen >= 15, 1'b1);
    own_q.delete();

    // Async reset mid-OWN clears outputs before the next edge; index 0 wins afterwards.
    apply_reset(4'b1111);
    expect_out("areset_owned", 4'b0010, 4'h6);
    step(12);
    check_out();
    #2 rst_n = 1'b0;
    #1;
    expect_out("areset_clear", 4'b0000, 4'h0);
    check_out();
    check_bit("areset_tick", tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_out("areset_regrant", 4'b0001, 4'h0);
    expect_out("areset_led", 4'b0001, 4'h9);
    step(1);
    check_out();
    step(1);
    check_out();
    step(1);
    check_bit("areset_tick_c3", tick, 1'b0);
    step(1);
    check_bit("areset_tick_c4", tick, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
